// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and
// counter sizing. Intended to be reused by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read-side handshake between the byte FIFO and the UART drain.
interface uart_tx_drain_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              fifo_rd;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  // master: the drain issuing pops; slave: the FIFO serving them
  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_dout
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_dout
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit with tick.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Decode of a flop; consumed only by the FSM, never by the pad.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the byte FIFO one at a time and serialises each onto txd
// as start, LSB-first data, optional parity and 1..2 stop bits.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  uart_tx_drain_if.master        fifo,
  output logic                   txd,
  output logic                   busy,
  output logic                   tx_done
);

  localparam int unsigned      IDX_W    = cnt_width(DATA_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_IDX = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  uart_tx_state_e    state;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic              par_bit;
  logic              bit_active;
  logic              tick;

  assign shift_nxt  = shift_reg >> 1;
  assign bit_active = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);

  // Baud counter sits at zero outside the serial states so each bit starts clean.
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (!bit_active),
    .en   (bit_active),
    .tick (tick)
  );

  // Frame sequencer; every output is a flop so txd cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      txd          <= IDLE_LVL;
      fifo.fifo_rd <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      fifo.fifo_rd <= 1'b0;
      tx_done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          txd <= IDLE_LVL;
          if (tx_en && !fifo.fifo_empty) begin
            state        <= ST_FETCH;
            fifo.fifo_rd <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        // fifo_dout is valid the cycle after the pop
        ST_LOAD: begin
          shift_reg <= fifo.fifo_dout;
          par_bit   <= (^fifo.fifo_dout) ^ PAR_ODD;
          bit_idx   <= '0;
          txd       <= START_LVL;
          state     <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            txd   <= shift_reg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_reg <= shift_nxt;
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                txd   <= par_bit;
                state <= ST_PARITY;
              end else begin
                txd   <= IDLE_LVL;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              txd     <= shift_nxt[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            txd   <= IDLE_LVL;
            state <= ST_STOP;
          end
        end
        // bit_idx counts stop bits here
        ST_STOP: begin
          if (tick) begin
            if (bit_idx == STOP_IDX) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          txd   <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule
